// File: rtl/conv_window_ctrl.sv
// Streaming window-enable controller for the convolver: tracks the raster position of accepted
// pixels and raises out_valid with output-map coordinates for every complete, stride-aligned window.
module conv_window_ctrl #(
  parameter int IMAGE_W     = 28,
  parameter int IMAGE_H     = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int STRIDE      = 1,
  localparam int OUT_W      = (IMAGE_W - KERNEL_SIZE) / STRIDE + 1,
  localparam int OUT_H      = (IMAGE_H - KERNEL_SIZE) / STRIDE + 1,
  localparam int IMAGE_MAX  = (IMAGE_W > IMAGE_H) ? IMAGE_W : IMAGE_H,
  localparam int CW         = $clog2(IMAGE_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pixel_valid,
  output logic          pixel_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          busy,
  output logic          frame_done
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting pixels of the frame
  // DRAIN | last pixel taken, waiting for the final window to be handshaken
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMAGE_W - 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(IMAGE_H - 1);
  localparam logic [CW-1:0] EDGE_MIN  = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] OCOL_LAST = CW'(OUT_W - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);

  state_t        state;
  logic [CW-1:0] col, row, nxt_col, nxt_row;
  logic [PW-1:0] col_ph, row_ph;
  logic          accept, col_in, row_in, hit;

  assign pixel_ready = (state == RUN) && !(out_valid && !out_ready);
  assign busy        = (state != IDLE);
  assign accept      = pixel_valid && pixel_ready;
  assign col_in      = (col >= EDGE_MIN);
  assign row_in      = (row >= EDGE_MIN);
  // Phase counters start at the first full-window column/row, so phase 0 marks the stride grid.
  assign hit         = accept && col_in && row_in && (col_ph == '0) && (row_ph == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      col_ph     <= '0;
      row_ph     <= '0;
      nxt_col    <= '0;
      nxt_row    <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            col     <= '0;
            row     <= '0;
            col_ph  <= '0;
            row_ph  <= '0;
            nxt_col <= '0;
            nxt_row <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (hit) begin
              out_valid <= 1'b1;
              out_row   <= nxt_row;
              out_col   <= nxt_col;
              if (nxt_col == OCOL_LAST) begin
                nxt_col <= '0;
                nxt_row <= nxt_row + 1'b1;
              end else begin
                nxt_col <= nxt_col + 1'b1;
              end
            end
            if (col == COL_LAST) begin
              col    <= '0;
              col_ph <= '0;
              if (row == ROW_LAST) begin
                row    <= '0;
                row_ph <= '0;
                state  <= DRAIN;
              end else begin
                row <= row + 1'b1;
                if (row_in) row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
              if (col_in) col_ph <= (col_ph == PH_LAST) ? '0 : col_ph + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!out_valid || out_ready) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
